// File: rtl/axis_host_src_arb.sv
// axis_host_src_arb: packet-granular round-robin merge of the per-stream host
// source channels into one fully registered AXI4-Stream output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet in flight; pick the next valid stream round-robin
// BUSY  | grant held on grant_q until that stream's tlast beat is taken
module axis_host_src_arb #(
  parameter int N_STRM    = 4,
  parameter int DATA_BITS = 512,
  parameter int PID_BITS  = 6,
  localparam int KEEP_BITS = DATA_BITS / 8,
  localparam int GNT_BITS  = (N_STRM > 1) ? $clog2(N_STRM) : 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_STRM*DATA_BITS-1:0] s_axis_tdata,
  input  logic [N_STRM*KEEP_BITS-1:0] s_axis_tkeep,
  input  logic [N_STRM*PID_BITS-1:0]  s_axis_tid,
  input  logic [N_STRM-1:0]           s_axis_tlast,
  input  logic [N_STRM-1:0]           s_axis_tvalid,
  output logic [N_STRM-1:0]           s_axis_tready,
  output logic [DATA_BITS-1:0]        m_axis_tdata,
  output logic [KEEP_BITS-1:0]        m_axis_tkeep,
  output logic [PID_BITS-1:0]         m_axis_tid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [GNT_BITS-1:0]         grant_idx,
  output logic [31:0]                 pkt_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [GNT_BITS-1:0]  grant_q, grant_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic [KEEP_BITS-1:0] m_keep_q, m_keep_d;
  logic [PID_BITS-1:0]  m_id_q, m_id_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;

  logic                 load_en;
  logic                 accept;
  logic                 found;
  logic [GNT_BITS-1:0]  cand;
  logic [DATA_BITS-1:0] sel_data;
  logic [KEEP_BITS-1:0] sel_keep;
  logic [PID_BITS-1:0]  sel_id;
  logic                 sel_last;
  logic                 sel_valid;

  // The output register can take a new beat when empty or being drained.
  assign load_en = !m_valid_q || m_axis_tready;

  // Route the granted stream's beat onto a single select bus.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_id    = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_STRM; i++) begin
      if (grant_q == GNT_BITS'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
        sel_keep  = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
        sel_id    = s_axis_tid[i*PID_BITS +: PID_BITS];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // Next state: round-robin pick in IDLE, hold the grant through the packet in BUSY.
  // tready is derived from state and load_en only, never from any tvalid.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    found         = 1'b0;
    cand          = '0;
    case (state_q)
      IDLE: begin
        for (int off = 1; off <= N_STRM; off++) begin
          cand = GNT_BITS'((int'(grant_q) + off) % N_STRM);
          if (!found && s_axis_tvalid[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = BUSY;
      end
      BUSY: begin
        s_axis_tready[grant_q] = load_en && !areset;
        accept = load_en && !areset && sel_valid;
        if (accept && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and packet counter next values; contents hold while stalled.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_id_d    = m_id_q;
    if (load_en) begin
      m_valid_d = accept;
      if (accept) begin
        m_last_d = sel_last;
        m_data_d = sel_data;
        m_keep_d = sel_keep;
        m_id_d   = sel_id;
      end
    end
    pkt_cnt_d = pkt_cnt_q + {31'd0, m_valid_q && m_axis_tready && m_last_q};
  end

  // State, grant, output and counter registers; reset drops any partial packet.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= GNT_BITS'(N_STRM - 1);
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_id_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_id_q    <= m_id_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tid    = m_id_q;
  assign grant_idx     = grant_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule
